// File: rtl/regfile_wb_arbiter.sv
// Arbitrates the single regfile write port between the pipeline writeback and a small
// FIFO of multi-cycle unit results; tracks pending writes for hazard queries.
module regfile_wb_arbiter #(
  parameter int FIFO_DEPTH   = 2,
  parameter int STARVE_LIMIT = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pipe_we,
  input  logic [4:0]  pipe_waddr,
  input  logic [31:0] pipe_wdata,
  input  logic        aux_valid,
  input  logic [4:0]  aux_waddr,
  input  logic [31:0] aux_wdata,
  output logic        aux_ready,
  output logic        we,
  output logic [4:0]  waddr,
  output logic [31:0] wdata,
  input  logic [4:0]  q_addr1,
  input  logic [4:0]  q_addr2,
  output logic        q_hit1,
  output logic        q_hit2,
  output logic        stall_req,
  output logic        proto_err
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  logic [4:0]            ent_addr [FIFO_DEPTH];
  logic [31:0]           ent_data [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] ent_live;
  logic [PW-1:0]         head, tail;
  logic [CW-1:0]         count;
  logic [SW-1:0]         starve_cnt, starve_next;
  logic head_valid, head_live, grant, pop, accept, enq, pipe_kill, enq_live;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign head_valid = (count != '0);
  assign head_live  = head_valid && ent_live[head];
  assign grant      = head_live && !pipe_we;
  // A killed head leaves regardless of the pipe, so it never blocks the queue.
  assign pop        = head_valid && (!ent_live[head] || !pipe_we);
  assign aux_ready  = (count < CW'(FIFO_DEPTH));
  assign accept     = aux_valid && aux_ready;
  assign enq        = accept && (aux_waddr != 5'd0);
  assign pipe_kill  = pipe_we && (pipe_waddr != 5'd0);
  assign enq_live   = !(pipe_kill && (aux_waddr == pipe_waddr));

  always_comb begin
    we    = 1'b0;
    waddr = 5'd0;
    wdata = 32'd0;
    if (!rst) begin
      if (pipe_we) begin
        we    = (pipe_waddr != 5'd0);
        waddr = pipe_waddr;
        wdata = pipe_wdata;
      end else if (head_live) begin
        we    = 1'b1;
        waddr = ent_addr[head];
        wdata = ent_data[head];
      end
    end
  end

  // Live bits are cleared on pop, so a set live bit always marks a queued entry.
  always_comb begin
    q_hit1 = 1'b0;
    q_hit2 = 1'b0;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      if (ent_live[i] && (ent_addr[i] == q_addr1)) q_hit1 = 1'b1;
      if (ent_live[i] && (ent_addr[i] == q_addr2)) q_hit2 = 1'b1;
    end
    if (q_addr1 == 5'd0) q_hit1 = 1'b0;
    if (q_addr2 == 5'd0) q_hit2 = 1'b0;
  end

  always_comb begin
    starve_next = starve_cnt;
    if (!head_valid || grant)
      starve_next = '0;
    else if (head_live && (starve_cnt != SW'(STARVE_LIMIT)))
      starve_next = starve_cnt + SW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head       <= '0;
      tail       <= '0;
      count      <= '0;
      ent_live   <= '0;
      starve_cnt <= '0;
      stall_req  <= 1'b0;
      proto_err  <= 1'b0;
    end else begin
      for (int i = 0; i < FIFO_DEPTH; i++)
        if (pipe_kill && (ent_addr[i] == pipe_waddr)) ent_live[i] <= 1'b0;
      if (pop) begin
        ent_live[head] <= 1'b0;
        head           <= next_ptr(head);
      end
      if (enq) begin
        ent_live[tail] <= enq_live;
        tail           <= next_ptr(tail);
      end
      if (enq && !pop)
        count <= count + CW'(1);
      else if (pop && !enq)
        count <= count - CW'(1);
      starve_cnt <= starve_next;
      stall_req  <= (starve_next == SW'(STARVE_LIMIT));
      proto_err  <= proto_err | (pipe_we & stall_req);
    end
  end

  // Payload storage needs no reset; live bits alone decide validity.
  always_ff @(posedge clk) begin
    if (enq) begin
      ent_addr[tail] <= aux_waddr;
      ent_data[tail] <= aux_wdata;
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: directed scenarios plus randomized traffic
// compared against a queue-based reference model of the writeback arbitration rules.
module tb_regfile_wb_arbiter;

  localparam int DEPTH = 2;
  localparam int LIMIT = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        pipe_we, aux_valid;
  logic [4:0]  pipe_waddr, aux_waddr, q_addr1, q_addr2;
  logic [31:0] pipe_wdata, aux_wdata;
  logic        aux_ready, we, q_hit1, q_hit2, stall_req, proto_err;
  logic [4:0]  waddr;
  logic [31:0] wdata;

  int pass_cnt = 0;
  int total_cnt = 0;

  typedef struct {
    logic [4:0]  a;
    logic [31:0] d;
    bit          live;
  } ent_t;

  ent_t        mq[$];
  int          m_starve;
  bit          m_stall, m_proto;
  logic [31:0] model_rf [32];
  logic [31:0] dut_rf [32];
  bit          e_ready, e_we;
  logic [4:0]  e_waddr;
  logic [31:0] e_wdata;

  regfile_wb_arbiter #(.FIFO_DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst(rst),
    .pipe_we(pipe_we), .pipe_waddr(pipe_waddr), .pipe_wdata(pipe_wdata),
    .aux_valid(aux_valid), .aux_waddr(aux_waddr), .aux_wdata(aux_wdata),
    .aux_ready(aux_ready),
    .we(we), .waddr(waddr), .wdata(wdata),
    .q_addr1(q_addr1), .q_addr2(q_addr2), .q_hit1(q_hit1), .q_hit2(q_hit2),
    .stall_req(stall_req), .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  // Shadow regfile fed by whatever the DUT actually writes.
  always @(negedge clk) if (we) dut_rf[waddr] = wdata;

  function automatic bit model_hit(input logic [4:0] q);
    if (q == 5'd0) return 1'b0;
    foreach (mq[i]) if (mq[i].live && mq[i].a == q) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_comb();
    e_ready = (mq.size() < DEPTH);
    e_we = 1'b0; e_waddr = 5'd0; e_wdata = 32'd0;
    if (pipe_we) begin
      e_we = (pipe_waddr != 5'd0); e_waddr = pipe_waddr; e_wdata = pipe_wdata;
    end else if (mq.size() > 0 && mq[0].live) begin
      e_we = 1'b1; e_waddr = mq[0].a; e_wdata = mq[0].d;
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_starve = 0; m_stall = 1'b0; m_proto = 1'b0;
  endtask

  task automatic model_edge();
    bit ready_old, granted, do_pop;
    ent_t n;
    ready_old = (mq.size() < DEPTH);
    granted = (mq.size() > 0) && mq[0].live && !pipe_we;
    do_pop  = (mq.size() > 0) && (!mq[0].live || !pipe_we);
    if (mq.size() == 0 || granted) m_starve = 0;
    else if (mq[0].live && m_starve < LIMIT) m_starve++;
    m_proto = m_proto | (pipe_we && m_stall);
    m_stall = (m_starve == LIMIT);
    if (e_we) model_rf[e_waddr] = e_wdata;
    if (pipe_we && pipe_waddr != 5'd0)
      foreach (mq[i]) if (mq[i].a == pipe_waddr) mq[i].live = 1'b0;
    if (do_pop) void'(mq.pop_front());
    if (aux_valid && ready_old && aux_waddr != 5'd0) begin
      n.a = aux_waddr; n.d = aux_wdata;
      n.live = !(pipe_we && pipe_waddr == aux_waddr);
      mq.push_back(n);
    end
  endtask

  task automatic tick();
    model_comb();
    @(posedge clk);
    if (!rst) model_edge();
    #1;
  endtask

  task automatic idle();
    pipe_we = 1'b0; pipe_waddr = 5'd0; pipe_wdata = 32'd0;
    aux_valid = 1'b0; aux_waddr = 5'd0; aux_wdata = 32'd0;
    q_addr1 = 5'd0; q_addr2 = 5'd0;
  endtask

  task automatic test_reset();
    rst = 1'b1; idle(); model_reset();
    pipe_we = 1'b1; pipe_waddr = 5'd3; pipe_wdata = 32'h33;
    #2;
    total_cnt++; if (aux_ready !== 1'b1) $display("FAIL reset_aux_ready: got %0b want 1", aux_ready); else pass_cnt++;
    total_cnt++; if (we !== 1'b0) $display("FAIL reset_we: got %0b want 0", we); else pass_cnt++;
    total_cnt++; if (waddr !== 5'd0 || wdata !== 32'd0) $display("FAIL reset_wport: got %0d/%0h want 0/0", waddr, wdata); else pass_cnt++;
    total_cnt++; if (stall_req !== 1'b0 || proto_err !== 1'b0) $display("FAIL reset_flags: got %0b%0b want 00", stall_req, proto_err); else pass_cnt++;
    tick(); tick();
    rst = 1'b0; idle();
    tick();
  endtask

  task automatic test_aux_basic();
    aux_valid = 1'b1; aux_waddr = 5'd5; aux_wdata = 32'h11;
    #1;
    total_cnt++; if (we !== 1'b0) $display("FAIL aux_basic_c0_we: got %0b want 0", we); else pass_cnt++;
    tick(); idle(); #1;
    total_cnt++; if (we !== 1'b1 || waddr !== 5'd5 || wdata !== 32'h11)
      $display("FAIL aux_basic_c1_write: got %0b/%0d/%0h want 1/5/11", we, waddr, wdata); else pass_cnt++;
    tick(); #1;
    total_cnt++; if (we !== 1'b0 || aux_ready !== 1'b1) $display("FAIL aux_basic_empty: got we=%0b ready=%0b want 0/1", we, aux_ready); else pass_cnt++;
  endtask

  task automatic test_starve();
    pipe_we = 1'b1; pipe_waddr = 5'd3; pipe_wdata = 32'h33;
    aux_valid = 1'b1; aux_waddr = 5'd7; aux_wdata = 32'hAA;
    tick();
    aux_valid = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      #1;
      total_cnt++; if (stall_req !== 1'b0) $display("FAIL starve_early_c%0d: got %0b want 0", k, stall_req); else pass_cnt++;
      tick();
    end
    pipe_we = 1'b0; #1;
    total_cnt++; if (stall_req !== 1'b1) $display("FAIL starve_stall: got %0b want 1", stall_req); else pass_cnt++;
    total_cnt++; if (we !== 1'b1 || waddr !== 5'd7 || wdata !== 32'hAA)
      $display("FAIL starve_grant: got %0b/%0d/%0h want 1/7/aa", we, waddr, wdata); else pass_cnt++;
    tick(); #1;
    total_cnt++; if (stall_req !== 1'b0 || proto_err !== 1'b0) $display("FAIL starve_release: got %0b%0b want 00", stall_req, proto_err); else pass_cnt++;
    idle();
  endtask

  task automatic test_kill();
    aux_valid = 1'b1; aux_waddr = 5'd9; aux_wdata = 32'h1; q_addr1 = 5'd9;
    #1;
    total_cnt++; if (q_hit1 !== 1'b0) $display("FAIL kill_hit_before: got %0b want 0", q_hit1); else pass_cnt++;
    tick();
    aux_valid = 1'b0; pipe_we = 1'b1; pipe_waddr = 5'd9; pipe_wdata = 32'h2; #1;
    total_cnt++; if (q_hit1 !== 1'b1) $display("FAIL kill_hit_pending: got %0b want 1", q_hit1); else pass_cnt++;
    total_cnt++; if (we !== 1'b1 || waddr !== 5'd9 || wdata !== 32'h2)
      $display("FAIL kill_pipe_write: got %0b/%0d/%0h want 1/9/2", we, waddr, wdata); else pass_cnt++;
    tick();
    pipe_we = 1'b0; #1;
    total_cnt++; if (q_hit1 !== 1'b0 || we !== 1'b0) $display("FAIL kill_dead_pop: got hit=%0b we=%0b want 0/0", q_hit1, we); else pass_cnt++;
    tick(); tick();
    total_cnt++; if (dut_rf[9] !== 32'h2) $display("FAIL kill_final_r9: got %0h want 2", dut_rf[9]); else pass_cnt++;
    idle();
  endtask

  task automatic test_full_order();
    pipe_we = 1'b1; pipe_waddr = 5'd3; pipe_wdata = 32'h34;
    aux_valid = 1'b1; aux_waddr = 5'd10; aux_wdata = 32'hA1;
    tick();
    aux_waddr = 5'd11; aux_wdata = 32'hA2;
    tick();
    pipe_we = 1'b0; aux_waddr = 5'd12; aux_wdata = 32'hA3; #1;
    total_cnt++; if (aux_ready !== 1'b0) $display("FAIL full_ready: got %0b want 0", aux_ready); else pass_cnt++;
    total_cnt++; if (we !== 1'b1 || waddr !== 5'd10 || wdata !== 32'hA1)
      $display("FAIL full_first: got %0b/%0d/%0h want 1/10/a1", we, waddr, wdata); else pass_cnt++;
    tick(); #1;
    total_cnt++; if (aux_ready !== 1'b1 || waddr !== 5'd11 || wdata !== 32'hA2)
      $display("FAIL full_second: got rdy=%0b %0d/%0h want 1 11/a2", aux_ready, waddr, wdata); else pass_cnt++;
    tick();
    aux_valid = 1'b0; #1;
    total_cnt++; if (we !== 1'b1 || waddr !== 5'd12 || wdata !== 32'hA3 || aux_ready !== 1'b1)
      $display("FAIL full_third: got %0b/%0d/%0h rdy=%0b want 1/12/a3 1", we, waddr, wdata, aux_ready); else pass_cnt++;
    tick(); #1;
    total_cnt++; if (we !== 1'b0) $display("FAIL full_drained: got %0b want 0", we); else pass_cnt++;
    idle();
  endtask

  task automatic test_r0_proto();
    aux_valid = 1'b1; aux_waddr = 5'd0; aux_wdata = 32'hDEAD;
    tick(); idle(); #1;
    total_cnt++; if (we !== 1'b0 || aux_ready !== 1'b1) $display("FAIL r0_discard: got we=%0b rdy=%0b want 0/1", we, aux_ready); else pass_cnt++;
    tick();
    pipe_we = 1'b1; pipe_waddr = 5'd3; pipe_wdata = 32'h35;
    aux_valid = 1'b1; aux_waddr = 5'd7; aux_wdata = 32'hBB;
    tick();
    aux_valid = 1'b0;
    tick(); tick(); tick(); #1;
    total_cnt++; if (stall_req !== 1'b1 || proto_err !== 1'b0) $display("FAIL proto_pre: got %0b%0b want 10", stall_req, proto_err); else pass_cnt++;
    tick();
    pipe_we = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      total_cnt++; if (proto_err !== 1'b1) $display("FAIL proto_hold_%0d: got %0b want 1", k, proto_err); else pass_cnt++;
      tick();
    end
    idle();
  endtask

  task automatic test_reset_mid();
    pipe_we = 1'b1; pipe_waddr = 5'd3; pipe_wdata = 32'h36;
    aux_valid = 1'b1; aux_waddr = 5'd20; aux_wdata = 32'hC1;
    tick();
    aux_waddr = 5'd21; aux_wdata = 32'hC2;
    tick();
    rst = 1'b1; model_reset(); q_addr1 = 5'd20; #1;
    total_cnt++; if (aux_ready !== 1'b1 || we !== 1'b0 || stall_req !== 1'b0 || proto_err !== 1'b0)
      $display("FAIL rstmid_async: got rdy=%0b we=%0b st=%0b pe=%0b want 1000", aux_ready, we, stall_req, proto_err); else pass_cnt++;
    total_cnt++; if (q_hit1 !== 1'b0) $display("FAIL rstmid_hit: got %0b want 0", q_hit1); else pass_cnt++;
    tick();
    rst = 1'b0; idle();
    for (int k = 0; k < 3; k++) begin
      #1;
      total_cnt++; if (we !== 1'b0) $display("FAIL rstmid_nowrite_%0d: got %0b want 0", k, we); else pass_cnt++;
      tick();
    end
  endtask

  task automatic test_random();
    int bad;
    for (int c = 0; c < 400; c++) begin
      pipe_we    = m_stall ? ($urandom_range(0, 9) == 0) : ($urandom_range(0, 1) == 1);
      pipe_waddr = 5'($urandom_range(0, 7));
      pipe_wdata = $urandom;
      aux_valid  = ($urandom_range(0, 2) != 0);
      aux_waddr  = 5'($urandom_range(0, 7));
      aux_wdata  = $urandom;
      q_addr1    = 5'($urandom_range(0, 7));
      q_addr2    = 5'($urandom_range(0, 7));
      #1;
      model_comb();
      total_cnt++;
      if (we !== e_we || waddr !== e_waddr || wdata !== e_wdata || aux_ready !== e_ready ||
          q_hit1 !== model_hit(q_addr1) || q_hit2 !== model_hit(q_addr2) ||
          stall_req !== m_stall || proto_err !== m_proto)
        $display("FAIL random_c%0d: got we=%0b %0d/%0h rdy=%0b h=%0b%0b st=%0b pe=%0b want we=%0b %0d/%0h rdy=%0b h=%0b%0b st=%0b pe=%0b",
                 c, we, waddr, wdata, aux_ready, q_hit1, q_hit2, stall_req, proto_err,
                 e_we, e_waddr, e_wdata, e_ready, model_hit(q_addr1), model_hit(q_addr2), m_stall, m_proto);
      else pass_cnt++;
      tick();
    end
    idle(); tick(); tick(); tick();
    bad = 0;
    for (int r = 0; r < 32; r++) if (dut_rf[r] !== model_rf[r]) bad++;
    total_cnt++; if (bad != 0) $display("FAIL random_regfile: got %0d differing regs want 0", bad); else pass_cnt++;
  endtask

  initial begin
    for (int r = 0; r < 32; r++) begin
      model_rf[r] = 32'd0;
      dut_rf[r] = 32'd0;
    end
    test_reset();
    test_aux_basic();
    test_starve();
    test_kill();
    test_full_order();
    test_r0_proto();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
